// File: rtl/sequence_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sequence_pkg : shared states and match pattern for the 1011 stimulus source
// Revision 1.0
// ----------------------------------------------------------------------------
package sequence_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int PATTERN_LEN = 4;
  localparam logic [PATTERN_LEN-1:0] PATTERN = 4'b1011;

  // Bit-index register width; a one-bit word still needs a (constant zero) index.
  function automatic int idx_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sequence_pattern_tracker.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sequence_pattern_tracker : ideal overlapping 1011 Moore detector + match count
// Revision 1.0
// ----------------------------------------------------------------------------
module sequence_pattern_tracker
  import sequence_pkg::*;
#(
  parameter int COUNT_W = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               i_bit,
  output logic               o_match,
  output logic [COUNT_W-1:0] o_count
);

  logic [PATTERN_LEN-1:0] r_hist;
  logic [PATTERN_LEN-1:0] w_hist_nxt;
  logic [COUNT_W-1:0]     r_count;
  logic                   w_hit_nxt;
  logic                   w_saturated;

  assign w_hist_nxt  = {r_hist[PATTERN_LEN-2:0], i_bit};
  assign w_hit_nxt   = (w_hist_nxt == PATTERN);
  assign w_saturated = (r_count == {COUNT_W{1'b1}});

  // History shifts every clock, idle zeros included, exactly as a detector samples.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_hist  <= '0;
      r_count <= '0;
    end else begin
      r_hist <= w_hist_nxt;
      if (w_hit_nxt && !w_saturated) begin
        r_count <= r_count + COUNT_W'(1);
      end
    end
  end

  assign o_match = (r_hist == PATTERN);
  assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/sequence_generator_1011.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sequence_generator_1011 : MSB-first word serialiser with built-in 1011 reference
// Revision 1.0
// ----------------------------------------------------------------------------
module sequence_generator_1011
  import sequence_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int COUNT_W = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               load_valid,
  output logic               load_ready,
  input  logic [WIDTH-1:0]   load_data,
  output logic               sequence_out,
  output logic               bit_valid,
  output logic               busy,
  output logic               expected_detect,
  output logic [COUNT_W-1:0] detect_count
);

  localparam int IDX_W = idx_width(WIDTH);
  localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(WIDTH - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [WIDTH-1:0]  r_shift;
  logic [WIDTH-1:0]  w_shift_nxt;
  logic [IDX_W-1:0]  r_idx;
  logic [IDX_W-1:0]  w_idx_nxt;
  logic              r_seq_out;
  logic              w_seq_out_nxt;
  logic              r_bit_valid;
  logic              w_bit_valid_nxt;
  logic              r_busy;
  logic              w_busy_nxt;
  logic              w_last_bit;
  logic              w_ready;

  // r_idx counts the bits still to follow the one on sequence_out.
  assign w_last_bit = (r_state == SHIFT) && (r_idx == '0);
  assign w_ready    = (r_state == IDLE) || w_last_bit;
  assign load_ready = w_ready && !reset;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_shift     <= '0;
      r_idx       <= '0;
      r_seq_out   <= 1'b0;
      r_bit_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_shift     <= w_shift_nxt;
      r_idx       <= w_idx_nxt;
      r_seq_out   <= w_seq_out_nxt;
      r_bit_valid <= w_bit_valid_nxt;
      r_busy      <= w_busy_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_shift_nxt     = r_shift;
    w_idx_nxt       = r_idx;
    w_seq_out_nxt   = r_seq_out;
    w_bit_valid_nxt = r_bit_valid;
    w_busy_nxt      = r_busy;

    case (r_state)
      IDLE: begin
        w_seq_out_nxt   = 1'b0;
        w_bit_valid_nxt = 1'b0;
        w_busy_nxt      = 1'b0;
        if (load_valid) begin
          w_state_nxt     = SHIFT;
          w_seq_out_nxt   = load_data[WIDTH-1];
          w_shift_nxt     = load_data << 1;
          w_idx_nxt       = C_LAST_IDX;
          w_bit_valid_nxt = 1'b1;
          w_busy_nxt      = 1'b1;
        end
      end

      SHIFT: begin
        if (!w_last_bit) begin
          w_seq_out_nxt = r_shift[WIDTH-1];
          w_shift_nxt   = r_shift << 1;
          w_idx_nxt     = r_idx - IDX_W'(1);
        end else if (load_valid) begin
          // Back-to-back: the new MSB follows the old LSB with no gap.
          w_seq_out_nxt   = load_data[WIDTH-1];
          w_shift_nxt     = load_data << 1;
          w_idx_nxt       = C_LAST_IDX;
          w_bit_valid_nxt = 1'b1;
          w_busy_nxt      = 1'b1;
        end else begin
          w_state_nxt     = IDLE;
          w_seq_out_nxt   = 1'b0;
          w_bit_valid_nxt = 1'b0;
          w_busy_nxt      = 1'b0;
          w_idx_nxt       = '0;
        end
      end

      default: begin
        w_state_nxt     = IDLE;
        w_seq_out_nxt   = 1'b0;
        w_bit_valid_nxt = 1'b0;
        w_busy_nxt      = 1'b0;
      end
    endcase
  end

  assign sequence_out = r_seq_out;
  assign bit_valid    = r_bit_valid;
  assign busy         = r_busy;

  sequence_pattern_tracker #(
    .COUNT_W (COUNT_W)
  ) u_tracker (
    .clock   (clock),
    .reset   (reset),
    .i_bit   (r_seq_out),
    .o_match (expected_detect),
    .o_count (detect_count)
  );

endmodule
`default_nettype wire

// File: doc/sequence_generator_1011.md
Name: sequence_generator_1011

Overview:
Serial stimulus transmitter for the 1011 sequence detector. It accepts parallel words over a valid/ready handshake and shifts them out MSB-first, one bit per clock, on sequence_out. It also runs a reference model of an ideal overlapping 1011 Moore detector on the bits it emits, so benches and on-chip self-test can compare detector_out against expected_detect and detect_count.

Parameters:
WIDTH, 8, bits per loaded word (>= 1)
COUNT_W, 16, width of the saturating match counter

Ports:
clock  input  1  single system clock, all logic on rising edge
reset  input  1  asynchronous, active-high; clears all state
load_valid  input  1  load_data is offered this cycle
load_ready  output  1  block accepts a word this cycle
load_data  input  WIDTH  word to serialise, bit WIDTH-1 sent first
sequence_out  output  1  serial bit stream, registered; drives sequence_in of the detector
bit_valid  output  1  sequence_out carries a data bit (0 while idle)
busy  output  1  a word is being shifted
expected_detect  output  1  ideal detector output for the stream so far
detect_count  output  COUNT_W  number of 1011 matches in the emitted stream, saturating

Behaviour:
- Reset (asynchronous assert, synchronous release at the next edge): state=IDLE; sequence_out=0; bit_valid=0; busy=0; load_ready=1 once reset deasserts; history=0000; expected_detect=0; detect_count=0. Asserting reset mid-word drops the word with no partial completion.
- States: IDLE, SHIFT.
- IDLE: load_ready=1; sequence_out=0; bit_valid=0.
  - On load_valid&&load_ready: latch load_data into the shift register, set bit index = WIDTH-1, and go to SHIFT.
  - Next cycle: sequence_out=load_data[WIDTH-1], bit_valid=1, busy=1. Load-to-first-bit latency is 1 clock.
- SHIFT: each clock advances one bit, MSB to LSB; each bit is held for exactly 1 clock.
  - load_ready=0, except on the cycle carrying bit 0 (the last bit), when load_ready=1.
  - If a word is accepted on the last-bit cycle, its MSB appears the next clock. There is no gap: stream is back-to-back and busy stays 1.
  - If no word is accepted on the last bit: go to IDLE; the next cycle shows sequence_out=0, bit_valid=0, busy=0.
- load_valid while load_ready=0 is ignored; the source holds the word until accepted.
- Reference model:
  - 4-bit history updates every clock, including idle cycles where sequence_out=0, because the detector samples every clock: hist <= {hist[2:0], sequence_out}.
  - expected_detect = (hist == 4'b1011). It asserts the clock after the final 1 of a match is on sequence_out, matching Moore timing.
  - Overlap is allowed: 1011011 gives 2 matches.
  - detect_count increments by 1 on each clock where hist transitions into 1011, i.e. the next-state history equals 1011. It saturates at all-ones, with no wrap.
- WIDTH=1: every accepted word is a single bit; load_ready stays 1 throughout SHIFT.

Decomposition:
- Shared package sequence_pkg holds:
  - the state enum (IDLE, SHIFT)
  - the constant PATTERN = 4'b1011
  - PATTERN_LEN = 4
- One sub-module is natural: sequence_pattern_tracker. It contains the history register, the expected_detect compare and the saturating counter, parameterised by COUNT_W. The same module is reusable as a golden model beside the detector.

Test Plan:
- Reset, then idle 10 clocks -> sequence_out=0, bit_valid=0, load_ready=1, expected_detect=0, detect_count=0.
- Load 8'b1011_0000 -> sequence_out is 1,0,1,1,0,0,0,0 over clocks 1..8 after accept. expected_detect pulses 1 clock after the 4th bit. detect_count=1. Afterwards busy=0.
- Back-to-back loads 8'b1011_0110 then 8'b1100_0000, with load_valid held -> second word accepted on the last-bit cycle, no gap. Stream 1011011011 yields 3 overlapping matches, so detect_count=3.
- load_valid asserted mid-word -> not accepted until the last-bit cycle. Word content is unchanged and no bit is dropped or duplicated.
- Reset asserted asynchronously at bit 3 of 8'b1111_1011 -> all outputs clear immediately, without waiting for a clock edge. Subsequent load 8'b0000_1011 gives detect_count=1, with no stale history.
- COUNT_W=2, stream of 5 matches -> detect_count=3 and holds (saturation).
